// File: rtl/mem_split32_if.sv
// Split-transaction 32-bit memory bus: address phase closes on ack, read data returns on resp.
interface mem_split32_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );
endinterface

// File: rtl/accel_sum_master.sv
// Accelerator engine: on a start edge, reads len words from src, sums them (mod 2**32)
// and writes the sum to dst over a split-transaction bus.
module accel_sum_master #(
    parameter int unsigned LEN_W        = 16,
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_split32_if.master    bus,
    input  logic             accel_sw_on_i,
    input  logic             accel_start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             accel_rdy_o,
    output logic             accel_int_fin_o,
    output logic             err_o,
    output logic [31:0]      result_o
);

    localparam logic [2:0] StOff    = 3'd0;
    localparam logic [2:0] StIdle   = 3'd1;
    localparam logic [2:0] StRdReq  = 3'd2;
    localparam logic [2:0] StRdWait = 3'd3;
    localparam logic [2:0] StWrReq  = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             start_q;
    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      tmo_q, tmo_d;
    logic             abort_q, abort_d;
    logic             cap_v_q, cap_v_d;
    logic [31:0]      cap_q, cap_d;
    logic             req_q, req_d, we_q, we_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             err_q, err_d;
    logic [31:0]      result_q, result_d;

    logic             start_edge, abort, rd_valid;
    logic [31:0]      rd_data, acc_sum;
    logic [LEN_W-1:0] cnt_inc;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        tmo_d     = tmo_q;
        abort_d   = abort_q;
        cap_v_d   = cap_v_q;
        cap_d     = cap_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        result_d  = result_q;

        start_edge = accel_start_i & ~start_q;
        abort      = abort_q | ~accel_sw_on_i;
        // A resp that arrived together with ack was captured on the ack cycle.
        rd_valid   = cap_v_q | bus.resp;
        rd_data    = cap_v_q ? cap_q : bus.rdata;
        acc_sum    = acc_q + rd_data;
        cnt_inc    = cnt_q + LEN_W'(1);

        unique case (state_q)
            StOff: begin
                abort_d = 1'b0;
                if (accel_sw_on_i) state_d = StIdle;
            end
            StIdle: begin
                abort_d = 1'b0;
                if (!accel_sw_on_i) begin
                    state_d = StOff;
                end else if (start_edge) begin
                    src_d = src_addr_i;
                    dst_d = dst_addr_i;
                    len_d = len_i;
                    acc_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    req_d = 1'b1;
                    be_d  = 4'hF;
                    if (len_i == '0) begin
                        we_d    = 1'b1;
                        addr_d  = dst_addr_i;
                        wdata_d = '0;
                        state_d = StWrReq;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = src_addr_i;
                        state_d = StRdReq;
                    end
                end
            end
            StRdReq: begin
                if (!accel_sw_on_i) abort_d = 1'b1;
                if (bus.ack) begin
                    req_d   = 1'b0;
                    tmo_d   = '0;
                    cap_v_d = bus.resp;
                    cap_d   = bus.rdata;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (!accel_sw_on_i) abort_d = 1'b1;
                cap_v_d = 1'b0;
                if (rd_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (abort) begin
                        state_d = StOff;
                    end else if (cnt_inc == len_q) begin
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = dst_q;
                        wdata_d = acc_sum;
                        state_d = StWrReq;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = src_q + (32'(cnt_inc) << 2);
                        state_d = StRdReq;
                    end
                end else if (RESP_TIMEOUT != 0 && tmo_q == RESP_TIMEOUT - 1) begin
                    err_d   = 1'b1;
                    state_d = abort ? StOff : StDone;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StWrReq: begin
                if (!accel_sw_on_i) abort_d = 1'b1;
                if (bus.ack) begin
                    req_d = 1'b0;
                    if (abort) begin
                        state_d = StOff;
                    end else begin
                        result_d = acc_q;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                state_d = accel_sw_on_i ? StIdle : StOff;
            end
            default: state_d = StOff;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StOff;
            start_q  <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            tmo_q    <= '0;
            abort_q  <= 1'b0;
            cap_v_q  <= 1'b0;
            cap_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= accel_start_i;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            tmo_q    <= tmo_d;
            abort_q  <= abort_d;
            cap_v_q  <= cap_v_d;
            cap_q    <= cap_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign bus.req         = req_q;
    assign bus.we          = we_q;
    assign bus.addr        = addr_q;
    assign bus.be          = be_q;
    assign bus.wdata       = wdata_q;
    assign accel_rdy_o     = (state_q == StIdle);
    assign accel_int_fin_o = (state_q == StDone);
    assign err_o           = err_q;
    assign result_o        = result_q;

endmodule

// File: tb/tb_accel_sum_master.sv
// Directed bench for accel_sum_master with a configurable split-transaction slave model.
module tb_accel_sum_master;

    logic        clk;
    logic        rst;
    logic        sw_on;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        rdy;
    logic        fin;
    logic        err;
    logic [31:0] result;

    mem_split32_if bus_if ();

    accel_sum_master #(
        .LEN_W        (16),
        .RESP_TIMEOUT (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bus             (bus_if),
        .accel_sw_on_i   (sw_on),
        .accel_start_i   (start),
        .src_addr_i      (src),
        .dst_addr_i      (dst),
        .len_i           (len),
        .accel_rdy_o     (rdy),
        .accel_int_fin_o (fin),
        .err_o           (err),
        .result_o        (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave model configuration and logs
    logic [31:0] mem [0:255];
    int          ack_delay = 0;
    int          resp_lat  = 1;
    bit          resp_en   = 1'b1;
    int          wait_cnt  = 0;
    int          resp_cnt  = 0;
    logic [31:0] resp_data;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    int          stab_bad  = 0;
    int          rd_cnt    = 0;
    int          wr_cnt    = 0;
    int          fin_cnt   = 0;
    logic [31:0] rd_log [0:15];
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_be;

    always @(negedge clk) begin
        bus_if.ack  = 1'b0;
        bus_if.resp = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0 && resp_en) begin
                bus_if.resp  = 1'b1;
                bus_if.rdata = resp_data;
            end
        end
        if (bus_if.req === 1'b1 && !rst) begin
            if (wait_cnt == 0) begin
                h_addr  = bus_if.addr;
                h_we    = bus_if.we;
                h_wdata = bus_if.wdata;
            end else if (bus_if.addr !== h_addr || bus_if.we !== h_we ||
                         bus_if.wdata !== h_wdata) begin
                stab_bad++;
            end
            if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                bus_if.ack = 1'b1;
                wait_cnt   = 0;
                if (bus_if.we) begin
                    wr_addr = bus_if.addr;
                    wr_data = bus_if.wdata;
                    wr_be   = bus_if.be;
                    wr_cnt++;
                end else begin
                    rd_log[rd_cnt % 16] = bus_if.addr;
                    rd_cnt++;
                    resp_data = mem[bus_if.addr[9:2]];
                    if (resp_lat == 0) begin
                        if (resp_en) begin
                            bus_if.resp  = 1'b1;
                            bus_if.rdata = resp_data;
                        end
                    end else begin
                        resp_cnt = resp_lat;
                    end
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) if (fin === 1'b1) fin_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rdy !== 1'b1 && n < 200);
        chk(tag, {31'b0, rdy}, 32'd1);
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
    endtask

    int rd_b, wr_b, fin_b;

    task automatic snap();
        rd_b  = rd_cnt;
        wr_b  = wr_cnt;
        fin_b = fin_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h0101_0101;
        mem[64] = 32'd1; mem[65] = 32'd2; mem[66] = 32'd3; mem[67] = 32'd4;
        mem[80] = 32'hFFFF_FFFF; mem[81] = 32'd2;
        mem[96] = 32'd5; mem[97] = 32'd6; mem[98] = 32'd7;
        rst = 1'b1; sw_on = 1'b0; start = 1'b0;
        src = '0; dst = '0; len = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req",    {31'b0, bus_if.req}, 32'd0);
        chk("rst_we",     {31'b0, bus_if.we}, 32'd0);
        chk("rst_addr",   bus_if.addr, 32'd0);
        chk("rst_be",     {28'b0, bus_if.be}, 32'd0);
        chk("rst_wdata",  bus_if.wdata, 32'd0);
        chk("rst_rdy",    {31'b0, rdy}, 32'd0);
        chk("rst_fin",    {31'b0, fin}, 32'd0);
        chk("rst_err",    {31'b0, err}, 32'd0);
        chk("rst_result", result, 32'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("off_rdy", {31'b0, rdy}, 32'd0);
        sw_on = 1'b1;
        wait_rdy("on_rdy");

        // Basic sum: 1+2+3+4
        snap();
        launch(32'h100, 32'h200, 16'd4);
        wait_rdy("basic_done");
        chk("basic_nrd",  32'(rd_cnt - rd_b), 32'd4);
        chk("basic_rd0",  rd_log[(rd_b + 0) % 16], 32'h100);
        chk("basic_rd1",  rd_log[(rd_b + 1) % 16], 32'h104);
        chk("basic_rd2",  rd_log[(rd_b + 2) % 16], 32'h108);
        chk("basic_rd3",  rd_log[(rd_b + 3) % 16], 32'h10C);
        chk("basic_nwr",  32'(wr_cnt - wr_b), 32'd1);
        chk("basic_wadr", wr_addr, 32'h200);
        chk("basic_wdat", wr_data, 32'd10);
        chk("basic_wbe",  {28'b0, wr_be}, 32'hF);
        chk("basic_fin",  32'(fin_cnt - fin_b), 32'd1);
        chk("basic_res",  result, 32'd10);

        // Zero length
        snap();
        launch(32'h100, 32'h300, 16'd0);
        wait_rdy("zero_done");
        chk("zero_nrd",  32'(rd_cnt - rd_b), 32'd0);
        chk("zero_nwr",  32'(wr_cnt - wr_b), 32'd1);
        chk("zero_wadr", wr_addr, 32'h300);
        chk("zero_wdat", wr_data, 32'd0);
        chk("zero_fin",  32'(fin_cnt - fin_b), 32'd1);
        chk("zero_res",  result, 32'd0);

        // Overflow with ack backpressure
        snap();
        ack_delay = 3; resp_lat = 2;
        launch(32'h140, 32'h204, 16'd2);
        wait_rdy("ovf_done");
        chk("ovf_rd0",  rd_log[(rd_b + 0) % 16], 32'h140);
        chk("ovf_rd1",  rd_log[(rd_b + 1) % 16], 32'h144);
        chk("ovf_wadr", wr_addr, 32'h204);
        chk("ovf_wdat", wr_data, 32'h0000_0001);
        chk("ovf_res",  result, 32'h0000_0001);
        chk("ovf_stab", 32'(stab_bad), 32'd0);

        // Zero-latency slave: ack and resp together
        snap();
        ack_delay = 0; resp_lat = 0;
        launch(32'h180, 32'h208, 16'd3);
        wait_rdy("zl_done");
        chk("zl_nrd", 32'(rd_cnt - rd_b), 32'd3);
        chk("zl_res", result, 32'd18);
        resp_lat = 1;

        // Held start: one job only
        snap();
        launch(32'h108, 32'h20C, 16'd2);
        wait_rdy("held_done");
        repeat (8) @(negedge clk);
        chk("held_nrd", 32'(rd_cnt - rd_b), 32'd2);
        chk("held_nwr", 32'(wr_cnt - wr_b), 32'd1);
        chk("held_fin", 32'(fin_cnt - fin_b), 32'd1);
        chk("held_rdy", {31'b0, rdy}, 32'd1);
        chk("held_res", result, 32'd7);

        // Abort during the second read's wait
        snap();
        resp_lat = 3;
        launch(32'h100, 32'h210, 16'd4);
        for (int i = 0; i < 100 && rd_cnt - rd_b < 2; i++) @(negedge clk);
        @(negedge clk);
        sw_on = 1'b0;
        repeat (10) @(negedge clk);
        chk("abt_nrd", 32'(rd_cnt - rd_b), 32'd2);
        chk("abt_nwr", 32'(wr_cnt - wr_b), 32'd0);
        chk("abt_fin", 32'(fin_cnt - fin_b), 32'd0);
        chk("abt_rdy", {31'b0, rdy}, 32'd0);
        chk("abt_req", {31'b0, bus_if.req}, 32'd0);
        chk("abt_res", result, 32'd7);
        sw_on = 1'b1;
        wait_rdy("abt_back");
        resp_lat = 1;

        // Timeout: ack but never resp
        snap();
        resp_en = 1'b0;
        launch(32'h100, 32'h214, 16'd2);
        repeat (5) @(negedge clk);
        chk("tmo_early", {31'b0, err}, 32'd0);
        wait_rdy("tmo_done");
        chk("tmo_err", {31'b0, err}, 32'd1);
        chk("tmo_fin", 32'(fin_cnt - fin_b), 32'd1);
        chk("tmo_nwr", 32'(wr_cnt - wr_b), 32'd0);
        chk("tmo_nrd", 32'(rd_cnt - rd_b), 32'd1);
        chk("tmo_res", result, 32'd7);
        repeat (4) @(negedge clk);
        resp_en = 1'b1;
        launch(32'h10C, 32'h218, 16'd1);
        @(negedge clk);
        chk("tmo_clr", {31'b0, err}, 32'd0);
        wait_rdy("post_tmo_done");
        chk("post_tmo_res", result, 32'd4);

        // Reset mid-job
        launch(32'h100, 32'h21C, 16'd4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_req", {31'b0, bus_if.req}, 32'd0);
        chk("mrst_rdy", {31'b0, rdy}, 32'd0);
        chk("mrst_res", result, 32'd0);
        chk("mrst_adr", bus_if.addr, 32'd0);
        rst = 1'b0;
        chk("end_stab", 32'(stab_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
